aux_native_req_ctrl: RTL and testbench

//  Downstream consumer of the channel-EQ FSM AUX transaction interface (eq_data/eq_address/eq_len/eq_cmd/eq_transaction_vld).

---
 rtl/aux_pkg.sv | 32 +++
 rtl/aux_byte_fifo.sv | 72 +++++++
 rtl/aux_native_req_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_aux_native_req_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// -----------------------------------------------------------------------------
// aux_pkg
// Shared types and encodings for the AUX native request controller.
//   state_e           : controller FSM states
//   AUX_CMD_NATIVE_*  : 4-bit AUX request command nibbles (header byte [7:4])
//   AUX_REPLY_*       : reply code carried in bits [5:4] of the first reply byte
//   EQ_CMD_*          : command encodings on the eq_cmd input
// -----------------------------------------------------------------------------
package aux_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND_HDR,
    S_SEND_DATA,
    S_WAIT_REPLY,
    S_RX_DATA,
    S_ACK,
    S_FAIL
  } state_e;

  localparam logic [3:0] AUX_CMD_NATIVE_WR = 4'b1000;
  localparam logic [3:0] AUX_CMD_NATIVE_RD = 4'b1001;

  localparam logic [1:0] AUX_REPLY_ACK   = 2'b00;
  localparam logic [1:0] AUX_REPLY_NACK  = 2'b01;
  localparam logic [1:0] AUX_REPLY_DEFER = 2'b10;

  localparam logic [1:0] EQ_CMD_WR = 2'b00;
  localparam logic [1:0] EQ_CMD_RD = 2'b01;

endpackage

// File: rtl/aux_byte_fifo.sv
// -----------------------------------------------------------------------------
// aux_byte_fifo
// DEPTH x 8 write-data buffer. Reads are non-destructive: the read pointer
// walks the stored bytes and can be rewound to replay the whole payload.
// Ports:
//   clk, rst   : clock, async active-high reset (pointers only)
//   clr        : drop all contents (both pointers to 0)
//   wr_en      : store wr_data at the write pointer (ignored when full)
//   rd_en      : advance the read pointer
//   rewind     : return the read pointer to the first byte
//   rd_data    : byte at the read pointer
//   rd_ptr     : current read index
//   count      : number of bytes stored
// -----------------------------------------------------------------------------
module aux_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  input  logic                       rewind,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_fire;

  assign wr_fire = wr_en && !clr && (wr_ptr_q < FULL_CNT);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      if (rewind)      rd_ptr_d = '0;
      else if (rd_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign rd_ptr  = rd_ptr_q;
  assign count   = wr_ptr_q;

endmodule

// File: rtl/aux_native_req_ctrl.sv
// -----------------------------------------------------------------------------
// aux_native_req_ctrl
// Accepts one native AUX request from the channel-EQ FSM, buffers its write
// payload, serialises header + payload to the AUX PHY, parses the sink reply,
// retries on timeout (and on DEFER when enabled) and reports ack / failure.
// Configuration macro:
//   AUX_DEFER_RETRY_EN : defined   -> DEFER replies retry like a timeout
//                        undefined -> DEFER replies fail immediately
// Ports:
//   clk, rst                 : clock, async active-high reset
//   eq_transaction_vld       : request / write-data valid from the EQ FSM
//   eq_cmd, eq_address       : command (00 wr, 01 rd, 1x illegal), DPCD address
//   eq_len, eq_data          : byte count minus 1, write data byte
//   aux_tx_byte/vld/last     : request byte stream to the PHY
//   aux_tx_ready             : PHY takes a byte when vld & ready
//   aux_rx_byte/vld/last     : reply byte stream from the PHY
//   ctrl_rd_data/vld         : read reply data, one cycle per byte
//   ctrl_ack_flag            : one-cycle pulse, transaction acknowledged
//   ctrl_native_failed       : one-cycle pulse, transaction failed
//   busy                     : high from acceptance until the ack/fail pulse
// Handshake: a tx byte transfers on a rising edge where aux_tx_vld and
// aux_tx_ready are both high; aux_tx_vld/byte/last hold steady until then.
// -----------------------------------------------------------------------------
module aux_native_req_ctrl
  import aux_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 40,
  parameter int MAX_RETRY   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eq_transaction_vld,
  input  logic [1:0]  eq_cmd,
  input  logic [19:0] eq_address,
  input  logic [7:0]  eq_len,
  input  logic [7:0]  eq_data,
  output logic [7:0]  aux_tx_byte,
  output logic        aux_tx_vld,
  input  logic        aux_tx_ready,
  output logic        aux_tx_last,
  input  logic [7:0]  aux_rx_byte,
  input  logic        aux_rx_vld,
  input  logic        aux_rx_last,
  output logic [7:0]  ctrl_rd_data,
  output logic        ctrl_rd_vld,
  output logic        ctrl_ack_flag,
  output logic        ctrl_native_failed,
  output logic        busy
);

  localparam int LEN_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = LEN_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [7:0]       MAX_LEN  = 8'(FIFO_DEPTH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_e           state_q, state_d;
  logic             cmd_rd_q, cmd_rd_d;
  logic [19:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             fail_q, fail_d;
  logic             rd_vld_q, rd_vld_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             fifo_wr, fifo_rd, fifo_rewind, fifo_clr;
  logic [7:0]       fifo_rd_data;
  logic [LEN_W-1:0] fifo_rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] len_plus1;
  logic             data_last;
  logic             retry_req;

  aux_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (eq_data),
    .rd_en   (fifo_rd),
    .rewind  (fifo_rewind),
    .rd_data (fifo_rd_data),
    .rd_ptr  (fifo_rd_ptr),
    .count   (fifo_cnt)
  );

  assign len_plus1 = {1'b0, len_q} + CNT_W'(1);
  assign data_last = (fifo_rd_ptr == len_q);

  // Tx stream is a decode of registered state only, so it drops with reset.
  always_comb begin
    aux_tx_vld  = 1'b0;
    aux_tx_byte = 8'h00;
    aux_tx_last = 1'b0;
    case (state_q)
      S_SEND_HDR: begin
        aux_tx_vld = 1'b1;
        case (hdr_idx_q)
          2'd0:    aux_tx_byte = {cmd_rd_q ? AUX_CMD_NATIVE_RD : AUX_CMD_NATIVE_WR, addr_q[19:16]};
          2'd1:    aux_tx_byte = addr_q[15:8];
          2'd2:    aux_tx_byte = addr_q[7:0];
          default: aux_tx_byte = 8'(len_q);
        endcase
        aux_tx_last = (hdr_idx_q == 2'd3) && cmd_rd_q;
      end
      S_SEND_DATA: begin
        aux_tx_vld  = 1'b1;
        aux_tx_byte = fifo_rd_data;
        aux_tx_last = data_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_rd_d    = cmd_rd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    hdr_idx_d   = hdr_idx_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rd_vld_d    = 1'b0;
    rd_data_d   = 8'h00;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    fifo_rewind = 1'b0;
    fifo_clr    = 1'b0;
    retry_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (eq_transaction_vld) begin
          cmd_rd_d    = (eq_cmd == EQ_CMD_RD);
          addr_d      = eq_address;
          len_d       = eq_len[LEN_W-1:0];
          hdr_idx_d   = 2'd0;
          retry_cnt_d = '0;
          rx_cnt_d    = '0;
          if (eq_cmd[1] || (eq_len > MAX_LEN)) begin
            state_d = S_FAIL;
          end else if (eq_cmd == EQ_CMD_RD) begin
            state_d = S_SEND_HDR;
          end else begin
            fifo_wr = 1'b1;  // accepting cycle carries data[0]
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (fifo_cnt == len_plus1) begin
          state_d = S_SEND_HDR;
        end else if (eq_transaction_vld) begin
          fifo_wr = 1'b1;
          if (fifo_cnt + CNT_W'(1) == len_plus1) state_d = S_SEND_HDR;
        end
      end
      S_SEND_HDR: begin
        if (aux_tx_ready) begin
          if (hdr_idx_q == 2'd3) begin
            hdr_idx_d = 2'd0;
            timer_d   = '0;
            state_d   = cmd_rd_q ? S_WAIT_REPLY : S_SEND_DATA;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      S_SEND_DATA: begin
        if (aux_tx_ready) begin
          fifo_rd = 1'b1;
          if (data_last) begin
            timer_d = '0;
            state_d = S_WAIT_REPLY;
          end
        end
      end
      S_WAIT_REPLY: begin
        // A reply byte takes priority over a timeout on the same cycle.
        if (aux_rx_vld) begin
          case (aux_rx_byte[5:4])
            AUX_REPLY_ACK: begin
              if (!cmd_rd_q || aux_rx_last) state_d = S_ACK;
              else                          state_d = S_RX_DATA;
            end
            AUX_REPLY_NACK: state_d = S_FAIL;
            AUX_REPLY_DEFER: begin
`ifdef AUX_DEFER_RETRY_EN
              retry_req = 1'b1;
`else
              state_d = S_FAIL;
`endif
            end
            default: state_d = S_FAIL;
          endcase
        end else if (timer_q == TMR_LAST) begin
          retry_req = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RX_DATA: begin
        if (aux_rx_vld) begin
          // Bytes beyond the requested length are consumed but not forwarded.
          if (rx_cnt_q < len_plus1) begin
            rd_vld_d  = 1'b1;
            rd_data_d = aux_rx_byte;
            rx_cnt_d  = rx_cnt_q + CNT_W'(1);
          end
          if (aux_rx_last) state_d = S_ACK;
        end
      end
      S_ACK, S_FAIL: begin
        fifo_clr = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Retry resends the identical request: header restarts, payload replays.
    if (retry_req) begin
      if (retry_cnt_q < RTY_MAX) begin
        retry_cnt_d = retry_cnt_q + RTY_W'(1);
        hdr_idx_d   = 2'd0;
        fifo_rewind = 1'b1;
        state_d     = S_SEND_HDR;
      end else begin
        state_d = S_FAIL;
      end
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_ACK) && (state_d != S_FAIL);
    ack_d  = (state_d == S_ACK);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_rd_q    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      hdr_idx_q   <= 2'd0;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      rx_cnt_q    <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      fail_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_rd_q    <= cmd_rd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      hdr_idx_q   <= hdr_idx_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      fail_q      <= fail_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy               = busy_q;
  assign ctrl_ack_flag      = ack_q;
  assign ctrl_native_failed = fail_q;
  assign ctrl_rd_vld        = rd_vld_q;
  assign ctrl_rd_data       = rd_data_q;

endmodule

// File: tb/tb_aux_native_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aux_native_req_ctrl
// Directed bench for aux_native_req_ctrl. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// Expectations follow the AUX_DEFER_RETRY_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_aux_native_req_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        eq_transaction_vld = 1'b0;
  logic [1:0]  eq_cmd = 2'b00;
  logic [19:0] eq_address = '0;
  logic [7:0]  eq_len = '0;
  logic [7:0]  eq_data = '0;
  logic [7:0]  aux_tx_byte;
  logic        aux_tx_vld;
  logic        aux_tx_ready = 1'b1;
  logic        aux_tx_last;
  logic [7:0]  aux_rx_byte = '0;
  logic        aux_rx_vld = 1'b0;
  logic        aux_rx_last = 1'b0;
  logic [7:0]  ctrl_rd_data;
  logic        ctrl_rd_vld;
  logic        ctrl_ack_flag;
  logic        ctrl_native_failed;
  logic        busy;

  aux_native_req_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .eq_transaction_vld (eq_transaction_vld),
    .eq_cmd             (eq_cmd),
    .eq_address         (eq_address),
    .eq_len             (eq_len),
    .eq_data            (eq_data),
    .aux_tx_byte        (aux_tx_byte),
    .aux_tx_vld         (aux_tx_vld),
    .aux_tx_ready       (aux_tx_ready),
    .aux_tx_last        (aux_tx_last),
    .aux_rx_byte        (aux_rx_byte),
    .aux_rx_vld         (aux_rx_vld),
    .aux_rx_last        (aux_rx_last),
    .ctrl_rd_data       (ctrl_rd_data),
    .ctrl_rd_vld        (ctrl_rd_vld),
    .ctrl_ack_flag      (ctrl_ack_flag),
    .ctrl_native_failed (ctrl_native_failed),
    .busy               (busy)
  );

  // ---------------- monitor ----------------
  logic [8:0] tx_log[$];   // {last, byte} of each accepted tx byte
  logic [7:0] rd_log[$];
  int         gap_log[$];  // idle cycles between tx bursts
  int         ack_cnt = 0, fail_cnt = 0, both_cnt = 0, rd_at_ack = 0, idle_run = 0;
  logic       seen_tx = 1'b0;
  logic       mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      tx_log.delete();
      rd_log.delete();
      gap_log.delete();
      ack_cnt   <= 0;
      fail_cnt  <= 0;
      rd_at_ack <= 0;
      idle_run  <= 0;
      seen_tx   <= 1'b0;
    end else begin
      if (aux_tx_vld && aux_tx_ready) tx_log.push_back({aux_tx_last, aux_tx_byte});
      if (aux_tx_vld) begin
        if (seen_tx && idle_run > 0) gap_log.push_back(idle_run);
        seen_tx  <= 1'b1;
        idle_run <= 0;
      end else if (seen_tx) begin
        idle_run <= idle_run + 1;
      end
      if (ctrl_rd_vld) rd_log.push_back(ctrl_rd_data);
      if (ctrl_ack_flag) begin
        ack_cnt   <= ack_cnt + 1;
        rd_at_ack <= rd_log.size();
      end
      if (ctrl_native_failed) fail_cnt <= fail_cnt + 1;
      if (ctrl_ack_flag && ctrl_native_failed) both_cnt <= both_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] wdata[16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected tx bytes of one request transmission.
  task automatic exp_req(input logic is_rd, input logic [19:0] addr, input logic [7:0] len);
    exp_q.push_back({1'b0, is_rd ? 4'b1001 : 4'b1000, addr[19:16]});
    exp_q.push_back({1'b0, addr[15:8]});
    exp_q.push_back({1'b0, addr[7:0]});
    exp_q.push_back({is_rd, len});
    if (!is_rd)
      for (int i = 0; i <= int'(len); i++)
        exp_q.push_back({(i == int'(len)), wdata[i]});
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("%s_tx[%0d]", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    tick();
  endtask

  task automatic send_req(input logic [1:0] cmd, input logic [19:0] addr,
                          input logic [7:0] len, input int nbytes);
    eq_cmd     = cmd;
    eq_address = addr;
    eq_len     = len;
    for (int i = 0; i < nbytes; i++) begin
      eq_transaction_vld = 1'b1;
      eq_data            = wdata[i];
      tick();
    end
    eq_transaction_vld = 1'b0;
  endtask

  task automatic send_reply(input logic [7:0] b, input logic last);
    aux_rx_vld  = 1'b1;
    aux_rx_byte = b;
    aux_rx_last = last;
    tick();
    aux_rx_vld  = 1'b0;
    aux_rx_last = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int i = 0;
    while (tx_log.size() < n && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_tx_wait"}, 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    while ((ack_cnt + fail_cnt) == 0 && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_done_wait"}, 32'((ack_cnt + fail_cnt) != 0), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({aux_tx_vld, aux_tx_last, aux_tx_byte, ctrl_rd_vld, ctrl_rd_data,
                ctrl_ack_flag, ctrl_native_failed, busy});
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_outs", all_outs(), 32'd0);

    // 1: single-byte write, ACK
    clear_logs();
    wdata[0] = 8'h21;
    send_req(2'b00, 20'h00102, 8'd0, 1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_tx(5, 50, "t1");
    send_reply(8'h00, 1'b1);
    wait_done(20, "t1");
    repeat (3) tick();
    exp_req(1'b0, 20'h00102, 8'd0);
    compare_tx("t1");
    check("t1_ack", 32'(ack_cnt), 32'd1);
    check("t1_fail", 32'(fail_cnt), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: six-byte read
    clear_logs();
    send_req(2'b01, 20'h00202, 8'd5, 1);
    check("t2_latency", 32'(aux_tx_vld), 32'd1);
    wait_tx(4, 50, "t2");
    send_reply(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_reply(8'h11 + 8'(i), (i == 5));
    wait_done(20, "t2");
    repeat (3) tick();
    exp_req(1'b1, 20'h00202, 8'd5);
    compare_tx("t2");
    check("t2_rd_count", 32'(rd_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++)
      check($sformatf("t2_rd[%0d]", i), 32'(rd_log[i]), 32'h11 + 32'(i));
    check("t2_rd_before_ack", 32'(rd_at_ack), 32'd6);
    check("t2_ack", 32'(ack_cnt), 32'd1);

    // 2b: reply ignored while idle; surplus read bytes dropped
    clear_logs();
    send_reply(8'h00, 1'b1);
    repeat (2) tick();
    check("t2b_idle_rx", 32'(ack_cnt + fail_cnt), 32'd0);
    send_req(2'b01, 20'h00010, 8'd1, 1);
    wait_tx(4, 50, "t2b");
    send_reply(8'h00, 1'b0);
    send_reply(8'hA1, 1'b0);
    send_reply(8'hA2, 1'b0);
    send_reply(8'hA3, 1'b1);
    wait_done(20, "t2b");
    repeat (3) tick();
    check("t2b_rd_count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() >= 2) begin
      check("t2b_rd0", 32'(rd_log[0]), 32'hA1);
      check("t2b_rd1", 32'(rd_log[1]), 32'hA2);
    end
    check("t2b_ack", 32'(ack_cnt), 32'd1);

    // 3: write len 3 with DEFER replies
    clear_logs();
    for (int i = 0; i < 4; i++) wdata[i] = 8'hA0 + 8'(i);
    send_req(2'b00, 20'h12345, 8'd3, 4);
    wait_tx(8, 60, "t3a");
    send_reply(8'h20, 1'b1);
`ifdef AUX_DEFER_RETRY_EN
    wait_tx(16, 60, "t3b");
    send_reply(8'h20, 1'b1);
    wait_tx(24, 60, "t3c");
    send_reply(8'h00, 1'b1);
    wait_done(20, "t3");
    repeat (3) tick();
    for (int k = 0; k < 3; k++) exp_req(1'b0, 20'h12345, 8'd3);
    compare_tx("t3");
    check("t3_ack", 32'(ack_cnt), 32'd1);
    check("t3_fail", 32'(fail_cnt), 32'd0);
`else
    wait_done(20, "t3");
    repeat (3) tick();
    exp_req(1'b0, 20'h12345, 8'd3);
    compare_tx("t3");
    check("t3_ack", 32'(ack_cnt), 32'd0);
    check("t3_fail", 32'(fail_cnt), 32'd1);
`endif

    // 4: read with no reply -> 8 transmissions then failure
    clear_logs();
    send_req(2'b01, 20'h0ABCD, 8'd0, 1);
    wait_tx(4, 50, "t4");
    // a new request while busy must be ignored
    eq_cmd = 2'b01;
    eq_address = 20'hFFFFF;
    eq_len = 8'd0;
    eq_transaction_vld = 1'b1;
    repeat (5) tick();
    eq_transaction_vld = 1'b0;
    wait_done(600, "t4");
    repeat (3) tick();
    for (int k = 0; k < 8; k++) exp_req(1'b1, 20'h0ABCD, 8'd0);
    compare_tx("t4");
    check("t4_fail", 32'(fail_cnt), 32'd1);
    check("t4_ack", 32'(ack_cnt), 32'd0);
    check("t4_gap_count", 32'(gap_log.size()), 32'd7);
    for (int i = 0; i < gap_log.size(); i++)
      check($sformatf("t4_gap[%0d]", i), 32'(gap_log[i]), 32'd40);

    // 4b: reply on the timeout cycle wins
    clear_logs();
    send_req(2'b01, 20'h00020, 8'd0, 1);
    wait_tx(4, 50, "t4b");
    repeat (39) tick();
    send_reply(8'h00, 1'b1);
    wait_done(20, "t4b");
    repeat (5) tick();
    check("t4b_ack", 32'(ack_cnt), 32'd1);
    check("t4b_fail", 32'(fail_cnt), 32'd0);
    check("t4b_tx_count", 32'(tx_log.size()), 32'd4);

    // 5: illegal command and illegal length
    clear_logs();
    send_req(2'b10, 20'h00100, 8'd0, 1);
    repeat (2) tick();
    check("t5_fail", 32'(fail_cnt), 32'd1);
    check("t5_no_tx", 32'(seen_tx), 32'd0);
    check("t5_ack", 32'(ack_cnt), 32'd0);
    clear_logs();
    send_req(2'b00, 20'h00100, 8'd16, 1);
    repeat (2) tick();
    check("t5b_fail", 32'(fail_cnt), 32'd1);
    check("t5b_no_tx", 32'(seen_tx), 32'd0);

    // 6: reset while stalled in the data phase
    clear_logs();
    wdata[0] = 8'h55;
    wdata[1] = 8'h66;
    send_req(2'b00, 20'h00400, 8'd1, 2);
    wait_tx(4, 50, "t6a");
    aux_tx_ready = 1'b0;
    repeat (2) tick();
    check("t6_stall_vld", 32'(aux_tx_vld), 32'd1);
    check("t6_stall_byte", 32'(aux_tx_byte), 32'h55);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_reset_outs", all_outs(), 32'd0);
    tick();
    rst = 1'b0;
    aux_tx_ready = 1'b1;
    tick();
    check("t6_no_pulse", 32'(ack_cnt + fail_cnt), 32'd0);
    clear_logs();
    wdata[0] = 8'h77;
    send_req(2'b00, 20'h00305, 8'd0, 1);
    wait_tx(5, 50, "t6b");
    send_reply(8'h00, 1'b1);
    wait_done(20, "t6");
    repeat (3) tick();
    exp_req(1'b0, 20'h00305, 8'd0);
    compare_tx("t6");
    check("t6_ack", 32'(ack_cnt), 32'd1);
    check("t6_fail", 32'(fail_cnt), 32'd0);

    check("no_dual_pulse", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
